// File: rtl/usb_tx_pipe.sv
// usb_tx_pipe: USB full-speed packet transmitter.
// Sends one descriptor (handshake, token or data packet) as SYNC, PID, body,
// CRC5/CRC16, bit stuffing, NRZI and EOP onto DP/DM, with an output enable.
module usb_tx_pipe #(
  parameter int MAX_BYTES = 8,
  parameter int BIT_DIV   = 1,
  parameter int SYNC_BITS = 8,
  parameter int LW        = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pkt_valid,
  output logic                   pkt_ready,
  input  logic [1:0]             pkt_kind,
  input  logic [3:0]             pid,
  input  logic [6:0]             addr,
  input  logic [3:0]             endp,
  input  logic [8*MAX_BYTES-1:0] data,
  input  logic [LW-1:0]          len,
  output logic                   dp,
  output logic                   dm,
  output logic                   oe,
  output logic                   busy,
  output logic                   done
);

  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int IW = $clog2(8*MAX_BYTES + SYNC_BITS + 17);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_TOKEN, S_DATA, S_CRC, S_EOP
  } state_t;

  state_t                 state, state_n;
  logic [IW-1:0]          idx, idx_n;
  logic [DW-1:0]          div, div_n;
  logic [2:0]             ones, ones_n;
  logic [15:0]            crc, crc_n;
  logic [7:0]             pid_sr, pid_n;
  logic [10:0]            tok_sr, tok_n;
  logic [8*MAX_BYTES-1:0] dat_sr, dat_n;
  logic [1:0]             kind_r, kind_n;
  logic [LW-1:0]          len_r, len_n;
  logic                   dp_n, dm_n, oe_n, busy_n, done_n, ready_n;
  logic                   emit, bit_v;
  logic                   strobe, is_tok, is_dat;
  logic [IW-1:0]          data_last;

  // Oversized payload lengths are limited to the buffer size.
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    if (l > LW'(MAX_BYTES)) return LW'(MAX_BYTES);
    return l;
  endfunction

  // One serial CRC step; token CRC5 lives in the low five bits.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b,
                                           input logic tok);
    logic        fb;
    logic [15:0] r;
    if (tok) begin
      fb = b ^ c[4];
      r  = {11'd0, c[3:0], 1'b0} ^ (fb ? 16'h0005 : 16'h0000);
    end else begin
      fb = b ^ c[15];
      r  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return r;
  endfunction

  assign strobe    = (div == DW'(BIT_DIV - 1));
  assign is_tok    = (kind_r == 2'b01);
  assign is_dat    = (kind_r == 2'b10);
  assign data_last = IW'({len_r, 3'b000}) - IW'(1);

  // Next-state logic: advances one line state per bit strobe; a pending
  // stuff bit always wins over the source bit, which is then held.
  always_comb begin
    state_n = state;   idx_n  = idx;    div_n  = div;   ones_n = ones;
    crc_n   = crc;     pid_n  = pid_sr; tok_n  = tok_sr; dat_n = dat_sr;
    kind_n  = kind_r;  len_n  = len_r;
    dp_n    = dp;      dm_n   = dm;     oe_n   = oe;    busy_n = busy;
    done_n  = 1'b0;    ready_n = pkt_ready;
    emit    = 1'b0;    bit_v  = 1'b0;
    if (state == S_IDLE) begin
      ready_n = 1'b1;
      if (pkt_valid) begin
        pid_n   = {~pid, pid};
        tok_n   = {endp, addr};
        dat_n   = data;
        kind_n  = pkt_kind;
        len_n   = clamp_len(len);
        crc_n   = 16'hFFFF;
        state_n = S_SYNC;
        idx_n   = IW'(1);
        div_n   = '0;
        ones_n  = '0;
        dp_n    = 1'b0;   // first SYNC zero: J -> K
        dm_n    = 1'b1;
        oe_n    = 1'b1;
        busy_n  = 1'b1;
        ready_n = 1'b0;
      end
    end else begin
      div_n = strobe ? '0 : div + DW'(1);
      if (strobe) begin
        if (ones == 3'd6) begin
          emit  = 1'b1;
          bit_v = 1'b0;
        end else begin
          case (state)
            S_SYNC: begin
              emit  = 1'b1;
              bit_v = (idx == IW'(SYNC_BITS - 1));
              if (bit_v) begin state_n = S_PID; idx_n = '0; end
              else idx_n = idx + IW'(1);
            end
            S_PID: begin
              emit  = 1'b1;
              bit_v = pid_sr[0];
              pid_n = pid_sr >> 1;
              if (idx == IW'(7)) begin
                idx_n = '0;
                if (is_tok)      state_n = S_TOKEN;
                else if (is_dat) state_n = (len_r == '0) ? S_CRC : S_DATA;
                else             state_n = S_EOP;
              end else idx_n = idx + IW'(1);
            end
            S_TOKEN: begin
              emit  = 1'b1;
              bit_v = tok_sr[0];
              tok_n = tok_sr >> 1;
              crc_n = crc_step(crc, bit_v, 1'b1);
              if (idx == IW'(10)) begin state_n = S_CRC; idx_n = '0; end
              else idx_n = idx + IW'(1);
            end
            S_DATA: begin
              emit  = 1'b1;
              bit_v = dat_sr[0];
              dat_n = dat_sr >> 1;
              crc_n = crc_step(crc, bit_v, 1'b0);
              if (idx == data_last) begin state_n = S_CRC; idx_n = '0; end
              else idx_n = idx + IW'(1);
            end
            S_CRC: begin
              emit  = 1'b1;
              bit_v = is_tok ? ~crc[4] : ~crc[15];
              crc_n = {crc[14:0], 1'b0};
              if (idx == IW'(is_tok ? 4 : 15)) begin state_n = S_EOP; idx_n = '0; end
              else idx_n = idx + IW'(1);
            end
            S_EOP: begin
              if (idx < IW'(2)) begin
                dp_n = 1'b0; dm_n = 1'b0; idx_n = idx + IW'(1);
              end else if (idx == IW'(2)) begin
                dp_n = 1'b1; dm_n = 1'b0; idx_n = IW'(3);
              end else begin
                state_n = S_IDLE; idx_n = '0;
                oe_n = 1'b0; busy_n = 1'b0; done_n = 1'b1; ready_n = 1'b1;
                dp_n = 1'b1; dm_n = 1'b0;
              end
            end
            default: state_n = S_IDLE;
          endcase
        end
        if (emit) begin
          ones_n = bit_v ? ones + 3'd1 : 3'd0;
          dp_n   = bit_v ? dp : ~dp;
          dm_n   = bit_v ? dm : ~dm;
        end
      end
    end
  end

  // Control and line registers; reset aborts any packet back to idle J.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE; idx <= '0; div <= '0; ones <= '0;
      dp <= 1'b1; dm <= 1'b0; oe <= 1'b0; busy <= 1'b0; done <= 1'b0;
      pkt_ready <= 1'b1;
    end else begin
      state <= state_n; idx <= idx_n; div <= div_n; ones <= ones_n;
      dp <= dp_n; dm <= dm_n; oe <= oe_n; busy <= busy_n; done <= done_n;
      pkt_ready <= ready_n;
    end
  end

  // Descriptor shift registers and CRC accumulator; loaded on accept.
  always_ff @(posedge clk) begin
    crc    <= crc_n;
    pid_sr <= pid_n;
    tok_sr <= tok_n;
    dat_sr <= dat_n;
    kind_r <= kind_n;
    len_r  <= len_n;
  end

endmodule

// File: tb/tb_usb_tx_pipe.sv
// Directed bench for usb_tx_pipe: two instances (BIT_DIV 1 and 4).
module tb_usb_tx_pipe;
  localparam int MB  = 8;
  localparam int LWB = $clog2(MB + 1);

  logic clk = 1'b0;
  logic rst;
  logic valid0, valid1, ready0, ready1;
  logic [1:0] kind;
  logic [3:0] pid;
  logic [6:0] addr;
  logic [3:0] endp;
  logic [63:0] data;
  logic [LWB-1:0] len;
  logic dp0, dm0, oe0, busy0, done0;
  logic dp1, dm1, oe1, busy1, done1;

  always #5 clk = ~clk;

  usb_tx_pipe #(.MAX_BYTES(MB), .BIT_DIV(1), .SYNC_BITS(8)) u0 (
    .clk(clk), .rst(rst), .pkt_valid(valid0), .pkt_ready(ready0),
    .pkt_kind(kind), .pid(pid), .addr(addr), .endp(endp), .data(data), .len(len),
    .dp(dp0), .dm(dm0), .oe(oe0), .busy(busy0), .done(done0));

  usb_tx_pipe #(.MAX_BYTES(MB), .BIT_DIV(4), .SYNC_BITS(8)) u1 (
    .clk(clk), .rst(rst), .pkt_valid(valid1), .pkt_ready(ready1),
    .pkt_kind(kind), .pid(pid), .addr(addr), .endp(endp), .data(data), .len(len),
    .dp(dp1), .dm(dm1), .oe(oe1), .busy(busy1), .done(done1));

  int nvec = 0;
  int nerr = 0;
  logic [1:0] exp_q[$];
  logic [1:0] cap_q[$];
  bit   dec_q[$];
  int   exp_stuffs, dec_stuffs, pay_stuffs;
  logic [15:0] exp_crc_tx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // {oe, busy, done, ready, dp, dm}
  function automatic logic [5:0] outs(input int inst);
    if (inst != 0) return {oe1, busy1, done1, ready1, dp1, dm1};
    return {oe0, busy0, done0, ready0, dp0, dm0};
  endfunction

  task automatic set_valid(input int inst, input logic v);
    if (inst != 0) valid1 = v; else valid0 = v;
  endtask

  // Reference model: raw bit list, then a stuffing pass, then NRZI + EOP.
  task automatic build_exp(input logic [1:0] k, input logic [3:0] p, input logic [6:0] a,
                           input logic [3:0] e, input logic [63:0] d, input int l);
    bit raw[$];
    bit body[$];
    logic [4:0]  c5;
    logic [15:0] c16;
    bit fb, lvl;
    int n, run;
    for (int i = 0; i < 7; i++) raw.push_back(1'b0);
    raw.push_back(1'b1);
    for (int i = 0; i < 4; i++) raw.push_back(p[i]);
    for (int i = 0; i < 4; i++) raw.push_back(~p[i]);
    exp_crc_tx = '0;
    if (k == 2'b01) begin
      for (int i = 0; i < 7; i++) body.push_back(a[i]);
      for (int i = 0; i < 4; i++) body.push_back(e[i]);
      c5 = 5'b11111;
      foreach (body[i]) begin
        fb = body[i] ^ c5[4];
        c5 = {c5[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
      end
      foreach (body[i]) raw.push_back(body[i]);
      for (int i = 4; i >= 0; i--) raw.push_back(~c5[i]);
      exp_crc_tx = {11'd0, ~c5};
    end else if (k == 2'b10) begin
      n = (l > MB) ? MB : l;
      for (int i = 0; i < 8*n; i++) body.push_back(d[i]);
      c16 = 16'hFFFF;
      foreach (body[i]) begin
        fb  = body[i] ^ c16[15];
        c16 = {c16[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
      foreach (body[i]) raw.push_back(body[i]);
      for (int i = 15; i >= 0; i--) raw.push_back(~c16[i]);
      exp_crc_tx = ~c16;
    end
    exp_q = {};
    exp_stuffs = 0;
    run = 0;
    lvl = 1'b1;
    foreach (raw[i]) begin
      if (!raw[i]) lvl = ~lvl;
      exp_q.push_back({lvl, ~lvl});
      run = raw[i] ? run + 1 : 0;
      if (run == 6) begin
        lvl = ~lvl;
        exp_q.push_back({lvl, ~lvl});
        exp_stuffs++;
        run = 0;
      end
    end
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endtask

  // Recover logical bits from captured line states (NRZI decode, destuff).
  task automatic decode(input int div);
    bit prev, b;
    int run;
    dec_q = {};
    dec_stuffs = 0;
    pay_stuffs = 0;
    prev = 1'b1;
    run = 0;
    for (int i = 0; i < cap_q.size(); i += div) begin
      if (cap_q[i] == 2'b00) break;
      b = (cap_q[i][1] == prev);
      prev = cap_q[i][1];
      if (run == 6) begin
        dec_stuffs++;
        if (dec_q.size() > 16 && dec_q.size() <= 32) pay_stuffs++;
        run = 0;
      end else begin
        dec_q.push_back(b);
        run = b ? run + 1 : 0;
      end
    end
  endtask

  function automatic logic [15:0] tail(input int n);
    logic [15:0] v;
    v = '0;
    for (int i = dec_q.size() - n; i < dec_q.size(); i++)
      if (i >= 0) v = {v[14:0], logic'(dec_q[i])};
    return v;
  endfunction

  // Send one packet, capture every oe-high cycle, compare with the model.
  task automatic run_pkt(input int inst, input logic [1:0] k, input logic [3:0] p,
                         input logic [6:0] a, input logic [3:0] e, input logic [63:0] d,
                         input logic [LWB-1:0] l, input string tag);
    int div, cyc, bad, first_bad;
    logic [5:0] o;
    div = (inst != 0) ? 4 : 1;
    build_exp(k, p, a, e, d, int'(l));
    o = outs(inst);
    check({tag, " ready before accept"}, o[2], 1'b1);
    kind = k; pid = p; addr = a; endp = e; data = d; len = l;
    set_valid(inst, 1'b1);
    @(posedge clk); #1;
    set_valid(inst, 1'b0);
    kind = ~k; pid = ~p; addr = ~a; endp = ~e; data = ~d; len = '0;
    o = outs(inst);
    check({tag, " oe/busy after accept"}, o[5:4], 2'b11);
    cap_q = {};
    cyc = 0;
    while (o[5] && cyc < 20000) begin
      cap_q.push_back(o[1:0]);
      @(posedge clk); #1;
      o = outs(inst);
      cyc++;
    end
    check({tag, " oe cycles"}, cyc, exp_q.size() * div);
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < cap_q.size() && i < exp_q.size() * div; i++)
      if (cap_q[i] !== exp_q[i / div]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    check($sformatf("%s line states (first bad cycle %0d)", tag, first_bad), bad, 0);
    check({tag, " end oe/busy/done/ready"}, o[5:2], 4'b0011);
    check({tag, " end line J"}, o[1:0], 2'b10);
    @(posedge clk); #1;
    o = outs(inst);
    check({tag, " done single cycle"}, o[3], 1'b0);
    decode(div);
  endtask

  initial begin
    int cyc, bad, accepts, dones;
    logic [15:0] dpv;
    logic [5:0]  eopv;
    rst = 1'b1; valid0 = 1'b0; valid1 = 1'b0;
    kind = '0; pid = '0; addr = '0; endp = '0; data = '0; len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset u0 outputs", outs(0), 6'b000110);
    check("reset u1 outputs", outs(1), 6'b000110);

    // ACK handshake
    run_pkt(0, 2'b00, 4'b0010, 7'd0, 4'd0, 64'd0, 4'd0, "ack");
    dpv = '0;
    for (int i = 0; i < 16; i++) dpv = {dpv[14:0], cap_q[i][1]};
    check("ack dp levels", dpv, 16'b0101010011011000);
    eopv = {cap_q[16], cap_q[17], cap_q[18]};
    check("ack eop states", eopv, 6'b000010);
    check("ack oe cycles hand", cap_q.size(), 19);

    // Kind 11 behaves as handshake
    run_pkt(0, 2'b11, 4'b1010, 7'h55, 4'hA, 64'hFF, 4'd3, "kind11");
    check("kind11 oe cycles hand", cap_q.size(), 19);

    // Token, addr 0 endp 0
    run_pkt(0, 2'b01, 4'b1101, 7'd0, 4'd0, 64'd0, 4'd0, "token0");
    check("token0 oe cycles hand", cap_q.size(), 35);
    check("token0 decoded bits", dec_q.size(), 32);
    check("token0 crc5 field", tail(5), 16'h0008);

    // Token with ones-heavy body
    run_pkt(0, 2'b01, 4'b1001, 7'h7F, 4'hF, 64'd0, 4'd0, "tokenff");
    check("tokenff crc5", tail(5), exp_crc_tx);
    check("tokenff stuffs", dec_stuffs, exp_stuffs);

    // Zero-length data
    run_pkt(0, 2'b10, 4'b0011, 7'd0, 4'd0, 64'd0, 4'd0, "data0");
    check("data0 oe cycles hand", cap_q.size(), 35);
    check("data0 crc16 zeros", tail(16), 16'h0000);

    // Two bytes of 0xFF
    run_pkt(0, 2'b10, 4'b1011, 7'd0, 4'd0, 64'h0000_0000_0000_FFFF, 4'd2, "dataff");
    check("dataff payload stuffs", pay_stuffs, 2);
    check("dataff total stuffs", dec_stuffs, exp_stuffs);
    check("dataff decoded bits", dec_q.size(), 48);
    check("dataff crc16", tail(16), exp_crc_tx);

    // BIT_DIV=4, len clamp, pkt_valid held across two packets
    build_exp(2'b10, 4'b0011, 7'd0, 4'd0, 64'h0123_4567_89AB_CDEF, 12);
    kind = 2'b10; pid = 4'b0011; addr = '0; endp = '0;
    data = 64'h0123_4567_89AB_CDEF; len = 4'd12;
    valid1 = 1'b1;
    accepts = 0; dones = 0; cyc = 0;
    cap_q = {};
    while (dones < 2 && cyc < 20000) begin
      if (ready1 && valid1) accepts++;
      @(posedge clk); #1;
      cyc++;
      if (dones == 0 && oe1) cap_q.push_back({dp1, dm1});
      if (done1) begin
        dones++;
        if (dones == 2) valid1 = 1'b0;
      end
    end
    check("held dones", dones, 2);
    check("held accepts", accepts, 2);
    check("div4 oe cycles", cap_q.size(), exp_q.size() * 4);
    bad = 0;
    for (int i = 0; i < cap_q.size() && i < exp_q.size() * 4; i++)
      if (cap_q[i] !== exp_q[i / 4]) bad++;
    check("div4 line states", bad, 0);
    decode(4);
    check("div4 clamped decoded bits", dec_q.size(), 96);
    @(posedge clk); #1;
    check("held no third accept", {oe1, ready1}, 2'b01);

    // Reset in the middle of a data payload
    kind = 2'b10; pid = 4'b0011; data = 64'hA5A5_5A5A_C3C3_3C3C; len = 4'd8;
    valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("mid data oe", oe0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort {oe,dp,dm,ready,done,busy}", {oe0, dp0, dm0, ready0, done0, busy0}, 6'b010100);
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (done0 || oe0) bad++;
    end
    check("abort stays idle", bad, 0);
    run_pkt(0, 2'b01, 4'b1101, 7'd0, 4'd0, 64'd0, 4'd0, "after reset");
    check("after reset crc5 field", tail(5), 16'h0008);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
